stack_sequencer: RTL and testbench

Multi-cycle sequencer for the stack-machine datapath. It fetches 32-bit instruction words, decodes the 6-bit opcode, and drives the stack RAM and the external combinational ALU through push / pop / operate sequences. It owns the program counter and stack pointer, and it sits between instruction memory, stack RAM and the ALU.

---
 rtl/stack_pkg.sv | 55 +++++
 rtl/stack_sequencer_if.sv | 41 ++++
 rtl/stack_ptr.sv | 38 +++
 rtl/stack_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the stack-machine sequencer.
//   - opcode constants (instr[31:26]) and ALU operation codes
//   - FSM state enum
//   - decode helpers used by the sequencer
package stack_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned ALU_W = 4;

    localparam logic [OPC_W-1:0] OP_HALT = 6'd0;
    localparam logic [OPC_W-1:0] OP_PUSH = 6'd1;
    localparam logic [OPC_W-1:0] OP_POP  = 6'd2;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'd3;
    localparam logic [OPC_W-1:0] OP_OR   = 6'd4;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'd5;
    localparam logic [OPC_W-1:0] OP_SLT  = 6'd6;
    localparam logic [OPC_W-1:0] OP_NOR  = 6'd7;

    localparam logic [ALU_W-1:0] ALU_NONE = 4'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'd7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_IMM,
        S_RD_B,
        S_RD_A,
        S_EXEC,
        S_HALT,
        S_ERR
    } state_e;

    // True for the two-operand ALU opcodes.
    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_NOR);
    endfunction

    // ALU code driven for an opcode; zero for non-ALU opcodes.
    function automatic logic [ALU_W-1:0] alu_code(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_OR:   return ALU_OR;
            OP_SUB:  return ALU_SUB;
            OP_SLT:  return ALU_SLT;
            OP_NOR:  return ALU_NOR;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: bundle between the sequencer and its environment
// (instruction memory, stack RAM, ALU, control/status).
//   master: sequencer side (drives pc, stack strobes, ALU operands, status)
//   slave : environment side (drives start, instr, stk_rdata, alu_y)
interface stack_sequencer_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              start;
    logic [31:0]       instr;
    logic [PC_W-1:0]   pc;
    logic              stk_we;
    logic              stk_re;
    logic [AW-1:0]     stk_addr;
    logic [DATA_W-1:0] stk_wdata;
    logic [DATA_W-1:0] stk_rdata;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic [AW:0]       sp;
    logic              busy;
    logic              halted;
    logic              err;

    modport master (
        input  start, instr, stk_rdata, alu_y,
        output pc, stk_we, stk_re, stk_addr, stk_wdata,
               alu_op, alu_a, alu_b, sp, busy, halted, err
    );

    modport slave (
        output start, instr, stk_rdata, alu_y,
        input  pc, stk_we, stk_re, stk_addr, stk_wdata,
               alu_op, alu_a, alu_b, sp, busy, halted, err
    );

endinterface

// File: rtl/stack_ptr.sv
// stack_ptr: stack depth register with clear/inc/dec and occupancy flags.
//   clock, reset : clock, async active-high reset
//   clear/inc/dec: update requests, clear has priority, then inc, then dec
//   sp           : current depth, wraps modulo 2*DEPTH
//   full_c/empty_c/lt2_c : combinational flags decoded from sp
module stack_ptr #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     inc,
    input  logic                     dec,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full_c,
    output logic                     empty_c,
    output logic                     lt2_c
);
    localparam int unsigned SP_W = $clog2(DEPTH) + 1;

    // Depth register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (inc) begin
            sp <= sp + SP_W'(1);
        end else if (dec) begin
            sp <= sp - SP_W'(1);
        end
    end

    assign full_c  = (sp == SP_W'(DEPTH));
    assign empty_c = (sp == '0);
    assign lt2_c   = (sp < SP_W'(2));

endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle fetch/decode/execute sequencer for the
// stack-machine datapath. Owns pc and sp, drives stack RAM and ALU.
//   clock, reset : clock, async active-high reset
//   bus (master) : start/instr in, pc out, stack RAM strobes/address/data,
//                  ALU op/operands/result, sp, busy/halted/err status
// Build option STACK_GUARD_EN: when defined, stack overflow/underflow at
// DECODE enters ERR without touching the stack; otherwise sp simply wraps.
// Illegal opcodes enter ERR in either build.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    stack_sequencer_if.master bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned SP_W = AW + 1;

    state_e              state_q, state_n;
    logic [PC_W-1:0]     pc_q, pc_n;
    logic [OPC_W-1:0]    ir_q, ir_n;
    logic [DATA_W-1:0]   a_q, a_n;
    logic [DATA_W-1:0]   b_q, b_n;

    logic                sp_inc, sp_dec, sp_clr;
    logic [SP_W-1:0]     sp;
    logic                full_c, empty_c, lt2_c;
    logic                push_blk_c, pop_blk_c, alu_blk_c;

    // Stack strobes are registered one state ahead so they are valid for
    // the whole state they belong to.
    logic                we_q, we_n;
    logic                re_q, re_n;
    logic [AW-1:0]       addr_q, addr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic [ALU_W-1:0]    alu_op_q;
    logic                busy_q, halted_q, err_q;

    stack_ptr #(.DEPTH(DEPTH)) u_stack_ptr (
        .clock   (clock),
        .reset   (reset),
        .clear   (sp_clr),
        .inc     (sp_inc),
        .dec     (sp_dec),
        .sp      (sp),
        .full_c  (full_c),
        .empty_c (empty_c),
        .lt2_c   (lt2_c)
    );

`ifdef STACK_GUARD_EN
    assign push_blk_c = full_c;
    assign pop_blk_c  = empty_c;
    assign alu_blk_c  = lt2_c;
`else
    logic unused_flags;
    assign unused_flags = ^{full_c, empty_c, lt2_c};
    assign push_blk_c   = 1'b0;
    assign pop_blk_c    = 1'b0;
    assign alu_blk_c    = 1'b0;
`endif

    // Next-state, datapath and look-ahead output decode.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        ir_n    = ir_q;
        a_n     = a_q;
        b_n     = b_q;
        sp_inc  = 1'b0;
        sp_dec  = 1'b0;
        sp_clr  = 1'b0;
        we_n    = 1'b0;
        re_n    = 1'b0;
        addr_n  = '0;
        wdata_n = '0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    pc_n    = '0;
                    sp_clr  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_n    = bus.instr[31:26];
                pc_n    = pc_q + PC_W'(1);
                state_n = S_DECODE;
                // Top-of-stack read must be on the bus during DECODE.
                if (is_alu_op(bus.instr[31:26]) && !alu_blk_c) begin
                    re_n   = 1'b1;
                    addr_n = AW'(sp - SP_W'(1));
                end
            end
            S_DECODE: begin
                case (ir_q)
                    OP_HALT: state_n = S_HALT;
                    OP_PUSH: begin
                        if (push_blk_c) begin
                            state_n = S_ERR;
                        end else begin
                            // pc already points at the immediate word.
                            state_n = S_IMM;
                            we_n    = 1'b1;
                            addr_n  = AW'(sp);
                            wdata_n = DATA_W'(bus.instr);
                        end
                    end
                    OP_POP: begin
                        if (pop_blk_c) begin
                            state_n = S_ERR;
                        end else begin
                            sp_dec  = 1'b1;
                            state_n = S_FETCH;
                        end
                    end
                    OP_ADD, OP_OR, OP_SUB, OP_SLT, OP_NOR: begin
                        if (alu_blk_c) begin
                            state_n = S_ERR;
                        end else begin
                            state_n = S_RD_B;
                            re_n    = 1'b1;
                            addr_n  = AW'(sp - SP_W'(2));
                        end
                    end
                    default: state_n = S_ERR;
                endcase
            end
            S_IMM: begin
                sp_inc  = 1'b1;
                pc_n    = pc_q + PC_W'(1);
                state_n = S_FETCH;
            end
            S_RD_B: begin
                b_n     = bus.stk_rdata;
                state_n = S_RD_A;
            end
            S_RD_A: begin
                a_n     = bus.stk_rdata;
                state_n = S_EXEC;
                we_n    = 1'b1;
                addr_n  = AW'(sp - SP_W'(2));
            end
            S_EXEC: begin
                sp_dec  = 1'b1;
                state_n = S_FETCH;
            end
            S_ERR:   state_n = S_ERR;
            default: state_n = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            alu_op_q <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            pc_q     <= pc_n;
            ir_q     <= ir_n;
            a_q      <= a_n;
            b_q      <= b_n;
            we_q     <= we_n;
            re_q     <= re_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            alu_op_q <= alu_code(ir_n);
            busy_q   <= (state_n != S_IDLE) && (state_n != S_HALT) && (state_n != S_ERR);
            halted_q <= (state_n == S_HALT);
            err_q    <= (state_n == S_ERR);
        end
    end

    assign bus.pc        = pc_q;
    assign bus.stk_we    = we_q;
    assign bus.stk_re    = re_q;
    assign bus.stk_addr  = addr_q;
    // The ALU is combinational, so its result is written through in EXEC.
    assign bus.stk_wdata = (state_q == S_EXEC) ? bus.alu_y : wdata_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.sp        = sp;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: directed self-checking bench for stack_sequencer with
// behavioural instruction memory, stack RAM and ALU.
module tb_stack_sequencer;
    import stack_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    stack_sequencer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    stack_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] imem [256];
    logic [31:0] ram [DEPTH];
    logic [31:0] rdata_q = '0;
    int          checks  = 0;
    int          errors  = 0;
    int          we_cnt  = 0;
    logic [3:0]  ops_seen [$];

    assign bus.instr     = imem[bus.pc];
    assign bus.stk_rdata = rdata_q;

    // Stack RAM: synchronous write, registered read.
    always @(posedge clock) begin
        if (bus.stk_we) ram[bus.stk_addr] <= bus.stk_wdata;
        if (bus.stk_re) rdata_q <= ram[bus.stk_addr];
    end

    // Combinational ALU; SLT is signed.
    always_comb begin
        case (bus.alu_op)
            4'd3:    bus.alu_y = bus.alu_a + bus.alu_b;
            4'd4:    bus.alu_y = bus.alu_a | bus.alu_b;
            4'd5:    bus.alu_y = bus.alu_a - bus.alu_b;
            4'd6:    bus.alu_y = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            4'd7:    bus.alu_y = ~(bus.alu_a | bus.alu_b);
            default: bus.alu_y = '0;
        endcase
    end

    // Strobe monitor: counts writes, records ALU codes of result writes.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.stk_we && bus.stk_re) begin
                errors++;
                $display("FAIL strobe_overlap: stk_we=1 and stk_re=1, required at most one");
            end
            if (bus.stk_we) begin
                we_cnt++;
                if (bus.alu_op != 4'd0) ops_seen.push_back(bus.alu_op);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] op_w(input logic [5:0] op);
        return {op, 26'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = op_w(OP_HALT);
    endtask

    // Returns #1 after the edge that samples start (edge 0).
    task automatic pulse_start();
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int edges, input int limit);
        edges = 0;
        while (!(bus.halted || bus.err)) begin
            if (edges >= limit) begin
                checks++;
                errors++;
                $display("FAIL timeout: no HALT/ERR within %0d edges", limit);
                return;
            end
            @(posedge clock);
            #1;
            edges++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n;
        int we0;

        bus.start = 1'b0;
        clear_imem();
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = '0;

        vecs[0] = '{OP_ADD, 32'd5,          32'd3,          32'd8};
        vecs[1] = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[2] = '{OP_OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF};
        vecs[3] = '{OP_SUB, 32'd5,          32'd3,          32'd2};
        vecs[4] = '{OP_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[5] = '{OP_SLT, 32'd3,          32'd5,          32'd1};
        vecs[6] = '{OP_SLT, 32'd5,          32'd3,          32'd0};
        vecs[7] = '{OP_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[8] = '{OP_NOR, 32'd0,          32'd5,          32'hFFFF_FFFA};
        vecs[9] = '{OP_NOR, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'd0};

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        check("rst_pc",     32'(bus.pc),       32'd0);
        check("rst_sp",     32'(bus.sp),       32'd0);
        check("rst_we",     32'(bus.stk_we),   32'd0);
        check("rst_re",     32'(bus.stk_re),   32'd0);
        check("rst_alu_op", 32'(bus.alu_op),   32'd0);
        check("rst_busy",   32'(bus.busy),     32'd0);
        check("rst_halted", 32'(bus.halted),   32'd0);
        check("rst_err",    32'(bus.err),      32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_busy", 32'(bus.busy), 32'd0);

        // PUSH a, PUSH b, OP, HALT: HALT reached on edge 13, result in RAM[0].
        for (int v = 0; v < 10; v++) begin
            clear_imem();
            imem[0] = op_w(OP_PUSH);
            imem[1] = vecs[v].a;
            imem[2] = op_w(OP_PUSH);
            imem[3] = vecs[v].b;
            imem[4] = op_w(vecs[v].op);
            pulse_start();
            check($sformatf("v%0d_busy_rise", v), 32'(bus.busy), 32'd1);
            wait_done(n, 100);
            check($sformatf("v%0d_edges", v),  32'(n),          32'd13);
            check($sformatf("v%0d_ram0", v),   ram[0],          vecs[v].y);
            check($sformatf("v%0d_sp", v),     32'(bus.sp),     32'd1);
            check($sformatf("v%0d_pc", v),     32'(bus.pc),     32'd6);
            check($sformatf("v%0d_halted", v), 32'(bus.halted), 32'd1);
            check($sformatf("v%0d_busy", v),   32'(bus.busy),   32'd0);
        end

        // PUSH 6, PUSH 3, SLT, PUSH 5, NOR, HALT.
        clear_imem();
        imem[0] = op_w(OP_PUSH); imem[1] = 32'd6;
        imem[2] = op_w(OP_PUSH); imem[3] = 32'd3;
        imem[4] = op_w(OP_SLT);
        imem[5] = op_w(OP_PUSH); imem[6] = 32'd5;
        imem[7] = op_w(OP_NOR);
        ops_seen.delete();
        pulse_start();
        wait_done(n, 100);
        check("seq_edges",   32'(n),               32'd21);
        check("seq_nops",    32'(ops_seen.size()), 32'd2);
        if (ops_seen.size() == 2) begin
            check("seq_op0", 32'(ops_seen[0]), 32'd6);
            check("seq_op1", 32'(ops_seen[1]), 32'd7);
        end
        check("seq_ram0",    ram[0],          32'hFFFF_FFFA);
        check("seq_ram1",    ram[1],          32'd5);
        check("seq_sp",      32'(bus.sp),     32'd1);
        check("seq_pc",      32'(bus.pc),     32'd9);

        // Reset during RD_A of an ADD aborts before the result write.
        clear_imem();
        imem[0] = op_w(OP_PUSH); imem[1] = 32'd1;
        imem[2] = op_w(OP_PUSH); imem[3] = 32'd2;
        imem[4] = op_w(OP_ADD);
        pulse_start();
        repeat (9) @(posedge clock);
        #1;
        check("rda_alu_op", 32'(bus.alu_op), 32'd3);
        check("rda_sp",     32'(bus.sp),     32'd2);
        reset = 1'b1;
        @(negedge clock);
        check("rda_rst_pc",   32'(bus.pc),     32'd0);
        check("rda_rst_sp",   32'(bus.sp),     32'd0);
        check("rda_rst_we",   32'(bus.stk_we), 32'd0);
        check("rda_rst_re",   32'(bus.stk_re), 32'd0);
        check("rda_rst_busy", 32'(bus.busy),   32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rda_ram0", ram[0],         32'd1);
        check("rda_idle", 32'(bus.busy),  32'd0);

        // Illegal opcode 0x3F: ERR after DECODE, sticky against start.
        clear_imem();
        imem[0] = {6'h3F, 26'd0};
        pulse_start();
        @(posedge clock);
        #1;
        check("ill_err_dec", 32'(bus.err), 32'd0);
        @(posedge clock);
        #1;
        check("ill_err",    32'(bus.err),    32'd1);
        check("ill_busy",   32'(bus.busy),   32'd0);
        check("ill_halted", 32'(bus.halted), 32'd0);
        pulse_start();
        repeat (3) @(posedge clock);
        #1;
        check("ill_sticky", 32'(bus.err),  32'd1);
        check("ill_pc",     32'(bus.pc),   32'd1);
        check("ill_busy2",  32'(bus.busy), 32'd0);
        apply_reset();
        #1;
        check("ill_clear", 32'(bus.err), 32'd0);

        // POP on an empty stack.
        clear_imem();
        imem[0] = op_w(OP_POP);
        we0 = we_cnt;
        pulse_start();
`ifdef STACK_GUARD_EN
        repeat (2) @(posedge clock);
        #1;
        check("pop_err",  32'(bus.err),     32'd1);
        check("pop_sp",   32'(bus.sp),      32'd0);
        check("pop_nowe", 32'(we_cnt - we0), 32'd0);
        pulse_start();
        repeat (3) @(posedge clock);
        #1;
        check("pop_sticky", 32'(bus.err), 32'd1);
        check("pop_pc",     32'(bus.pc),  32'd1);
        apply_reset();
`else
        wait_done(n, 50);
        check("pop_edges",  32'(n),            32'd4);
        check("pop_wrap",   32'(bus.sp),       32'd31);
        check("pop_halted", 32'(bus.halted),   32'd1);
        check("pop_nowe",   32'(we_cnt - we0), 32'd0);
`endif

        // 17 consecutive PUSHes at DEPTH=16.
        clear_imem();
        for (int i = 0; i < 17; i++) begin
            imem[2*i]   = op_w(OP_PUSH);
            imem[2*i+1] = 32'(100 + i);
        end
        we0 = we_cnt;
        pulse_start();
        wait_done(n, 300);
        check("p17_ram15", ram[15], 32'd115);
`ifdef STACK_GUARD_EN
        check("p17_edges", 32'(n),            32'd50);
        check("p17_err",   32'(bus.err),      32'd1);
        check("p17_sp",    32'(bus.sp),       32'd16);
        check("p17_we",    32'(we_cnt - we0), 32'd16);
`else
        check("p17_edges",  32'(n),            32'd53);
        check("p17_halted", 32'(bus.halted),   32'd1);
        check("p17_sp",     32'(bus.sp),       32'd17);
        check("p17_ram0",   ram[0],            32'd116);
        check("p17_we",     32'(we_cnt - we0), 32'd17);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
